// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: FSM encoding, default widths
// and the round-robin winner picker.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEF_W  = 3;
  localparam int unsigned DEF_PW = 4;
  localparam int unsigned MAXN   = 8;

  // Unused upper bits of valid are zero, so scanning mod MAXN from ptr (< N)
  // visits requesters in the same order as scanning mod N.
  function automatic logic [2:0] rr_pick(input logic [MAXN-1:0] valid,
                                         input logic [2:0]      ptr);
    logic [2:0] idx;
    logic       found;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAXN; k++) begin
      idx = ptr + 3'(k);
      if (!found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mul.sv
// Combinational unsigned multiplier; product truncated to PW bits.
module mul
  import alu_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int PW = DEF_PW
) (
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  output logic [PW-1:0] out
);

  logic [2*W-1:0] full;

  always_comb begin
    full = A * B;
    out  = PW'(full);
  end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter time-sharing one multiplier between N requesters,
// with registered operands and a backpressure-held tagged response.
module mul_share_arb
  import alu_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = DEF_W,
  parameter int PW  = DEF_PW,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [PW-1:0]  rsp_data,
  input  logic           rsp_ready,
  output logic           busy
);

  state_t          state, state_n;
  logic [IDW-1:0]  rr_ptr, id_q, win;
  logic [W-1:0]    a_q, b_q;
  logic [PW-1:0]   prod;
  logic [MAXN-1:0] valid_ext;
  logic            grant;

  mul #(.W(W), .PW(PW)) u_mul (
    .A  (a_q),
    .B  (b_q),
    .out(prod)
  );

  always_comb begin
    valid_ext          = '0;
    valid_ext[N-1:0]   = req_valid;
    win                = IDW'(rr_pick(valid_ext, 3'(rr_ptr)));
    grant              = (state == IDLE) && !rst && (|req_valid);
    req_ready          = '0;
    if (grant) req_ready = N'(1) << win;
    busy               = (state != IDLE);

    state_n = state;
    case (state)
      IDLE:    if (grant) state_n = MUL;
      MUL:     state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (grant) begin
          a_q    <= req_a[int'(win)*W +: W];
          b_q    <= req_b[int'(win)*W +: W];
          id_q   <= win;
          rr_ptr <= (win == IDW'(N-1)) ? '0 : win + 1'b1;
        end
        MUL: begin
          rsp_data  <= prod;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: vector table, scoreboard and
// hand-written multi-cycle sequences.
module tb_mul_share_arb;
  localparam int N = 4, W = 3, PW = 4, IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [PW-1:0]  rsp_data;
  logic           rsp_ready = 1'b0;
  logic           busy;

  mul_share_arb #(.N(N), .W(W), .PW(PW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [PW-1:0]  data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard: push on accepted request, pop on consumed response.
  int p;
  exp_t e;
  always @(negedge clk) if (!rst) begin
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) begin
      p = int'(req_a[i*W +: W]) * int'(req_b[i*W +: W]);
      sb.push_back('{id: IDW'(i), data: PW'(p % (1 << PW))});
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_rsp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_rsp_id", rsp_id, e.id);
        chk("sb_rsp_data", rsp_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic set_op(input int slot, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[slot*W +: W] = a;
    req_b[slot*W +: W] = b;
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 30) begin step(); #1; n++; end
    if (req_ready == '0) chk({name, "_grant_timeout"}, 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while ((busy || rsp_valid) && n < 30) begin step(); n++; end
    if (busy || rsp_valid) chk("drain_timeout", 0, 1);
  endtask

  typedef struct {
    int             slot;
    logic [W-1:0]   a, b;
    logic [PW-1:0]  exp_data;
  } vec_t;
  vec_t vecs[6];

  int t_prev, t_now;

  initial begin
    vecs[0] = '{slot: 2, a: 3'd2, b: 3'd5, exp_data: 4'b1010};
    vecs[1] = '{slot: 0, a: 3'd0, b: 3'd0, exp_data: 4'b0000};
    vecs[2] = '{slot: 1, a: 3'd1, b: 3'd1, exp_data: 4'b0001};
    vecs[3] = '{slot: 3, a: 3'd7, b: 3'd7, exp_data: 4'b0001};
    vecs[4] = '{slot: 2, a: 3'd7, b: 3'd3, exp_data: 4'b0101};
    vecs[5] = '{slot: 0, a: 3'd6, b: 3'd5, exp_data: 4'b1110};

    // Reset state, with requests pending during reset
    req_valid = '1;
    step(); step(); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);

    // Round robin: all valid, distinct operands
    for (int i = 0; i < N; i++) set_op(i, W'(i + 1), W'(i + 2));
    rsp_ready = 1'b1;
    rst = 1'b0;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr");
      t_now = cyc;
      chk("rr_grant", req_ready, 32'(1) << (k % N));
      if (k > 0) chk("rr_interval", t_now - t_prev, 3);
      t_prev = t_now;
      step();
    end
    req_valid = '0;
    drain();

    // Table of single requests, with latency checked each time
    foreach (vecs[v]) begin
      set_op(vecs[v].slot, vecs[v].a, vecs[v].b);
      req_valid = N'(1) << vecs[v].slot;
      wait_grant("vec");
      chk("vec_ready", req_ready, 32'(1) << vecs[v].slot);
      step();
      req_valid = '0;
      #1 chk("vec_mul_no_valid", rsp_valid, 0);
      step();
      #1 chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_id", rsp_id, vecs[v].slot);
      chk("vec_rsp_data", rsp_data, vecs[v].exp_data);
      drain();
    end

    // Backpressure: 7*3 from requester 1, consumer stalls for 5 cycles
    rsp_ready = 1'b0;
    set_op(1, 3'd7, 3'd3);
    set_op(2, 3'd4, 3'd3);
    req_valid = 4'b0010;
    wait_grant("bp");
    chk("bp_ready", req_ready, 4'b0010);
    step();
    req_valid = 4'b1111;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, 1);
      chk("bp_rsp_data", rsp_data, 4'b0101);
      chk("bp_req_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_ready_same_cycle", req_ready, 0);
    step();
    #1 chk("bp_next_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    drain();

    // Pointer wrap: bring rr_ptr to 3, then requesters 1 and 3 contend
    set_op(2, 3'd1, 3'd2);
    req_valid = 4'b0100;
    wait_grant("wrap_setup");
    step();
    req_valid = '0;
    drain();
    set_op(1, 3'd3, 3'd3);
    set_op(3, 3'd5, 3'd6);
    req_valid = 4'b1010;
    wait_grant("wrap_first");
    chk("wrap_first", req_ready, 4'b1000);
    step();
    wait_grant("wrap_second");
    chk("wrap_second", req_ready, 4'b0010);
    step();
    req_valid = '0;
    drain();

    // Reset in RESP: outputs clear asynchronously, pointer back to 0
    rsp_ready = 1'b0;
    set_op(2, 3'd5, 3'd5);
    req_valid = 4'b0100;
    wait_grant("rstmid");
    step();
    req_valid = '0;
    step();
    #1 chk("rstmid_pre_valid", rsp_valid, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_busy", busy, 0);
    req_valid = '1;
    #1 chk("rstmid_req_ready", req_ready, 0);
    sb.delete();
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    wait_grant("rstmid_after");
    chk("rstmid_first_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    drain();
    chk("sb_empty_at_end", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=%0d", cyc, 0);
    $fatal(1);
  end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Time-shares one combinational `mul` unit between N requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- Operands and the result are registered. Each response is tagged with the requester index and held under consumer backpressure.
- Sits between the ALU front-end request sources and the shared multiplier datapath.

Parameters:
- N, 4, number of requesters (2..8)
- W, 3, operand width per requester
- PW, 4, product width; result = (A*B) mod 2^PW
- IDW, 2, requester index width; must satisfy 2^IDW >= N

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  N  per-requester request valid
- req_a  in  N*W  operand A; requester i occupies bits [i*W +: W]
- req_b  in  N*W  operand B; same packing as req_a
- req_ready  out  N  one-hot accept strobe; requester i is accepted when req_valid[i] & req_ready[i]
- rsp_valid  out  1  result available
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_data  out  PW  product
- rsp_ready  in  1  consumer accepts the result when rsp_valid & rsp_ready
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock domain clk. rst is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - rr_ptr = 0
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0
  - operand registers = 0
  - req_ready = 0 (combinational, forced 0 while rst is high)
  - busy = 0
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - req_ready is combinational: one-hot at the winning index when state == IDLE and any req_valid is set; otherwise all zero.
  - Winner = first i with req_valid[i] set, scanning (rr_ptr, rr_ptr+1, ..., N-1, 0, ...). Index wraps mod N.
  - On a grant: latch a_q/b_q from the winner's slice, latch id_q = winner, set rr_ptr = (winner+1) mod N, go to MUL.
- MUL (1 cycle):
  - a_q/b_q drive the `mul` sub-module.
  - Register rsp_data = mul.out, rsp_id = id_q, rsp_valid = 1.
  - Go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_data stable until rsp_ready.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE.
  - A new grant is issued in the cycle after the handshake, not the same cycle.
- Latency: grant in cycle T; rsp_valid rises at edge T+2 (visible in cycle T+2). Throughput is at most one op per 3 cycles.
- req_ready is 0 in MUL and RESP. No requester is accepted while busy.
- Requester contract: must hold req_valid and its operands until it sees req_ready. The arbiter does not latch pending requests.
- A requester dropping req_valid before grant is legal; it simply is not served.
- Arithmetic: unsigned. Full product is 2W bits, truncated to the low PW bits.
  - Example with W=3, PW=4: 7*3 = 21 gives rsp_data = 4'b0101.
- Fairness: with all N requesters continuously valid, grants cycle 0,1,...,N-1,0. Each requester is served within N grants.
- Simultaneous events:
  - rsp_ready high outside RESP is ignored.
  - req_valid changes during MUL/RESP have no effect.
- Reset mid-operation: any in-flight result is discarded. rsp_valid drops immediately (asynchronous) and rr_ptr returns to 0.

Decomposition:
- Shared package `alu_pkg`:
  - FSM state encoding (IDLE = 0, MUL = 1, RESP = 2, 2-bit)
  - default W/PW constants
  - function `rr_pick(valid, ptr)` returning the winner index
- Sub-module: existing `mul` (A[W-1:0], B[W-1:0], out[PW-1:0]), instantiated once.
- Arbiter and FSM stay in mul_share_arb.

Test Plan:
- Reset mid-op:
  - rst asserted while in RESP with rsp_valid = 1 → rsp_valid, req_ready and busy go to 0 asynchronously.
  - After release, first grant with all req_valid set goes to requester 0.
- Single request:
  - Only req_valid[2] set, a = 3'b010, b = 3'b101, rsp_ready = 1 → req_ready = 4'b0100 at T.
  - rsp_valid at T+2 with rsp_id = 2, rsp_data = 4'b1010.
- Round robin: all four req_valid held high with distinct operands, rsp_ready = 1 → rsp_id sequence 0,1,2,3,0, one result every 3 cycles.
- Backpressure:
  - rsp_ready = 0 for 5 cycles after rsp_valid, request 7*3 → rsp_data = 4'b0101 and rsp_id held stable.
  - req_ready stays 0 throughout; next grant one cycle after rsp_ready rises.
- Edge operands: 0*0 → 0000, 1*1 → 0001, 7*7 → 4'b0001 (49 mod 16). Every response checked against (A*B) mod 16.
- Pointer wrap: rr_ptr = 3 with only req_valid[1] and req_valid[3] set → grant 3, then grant 1.
